sm_seq_gen: RTL

- Parametrised multi-stage sequence-checking FSM. Successor to the fixed 2-input, 4-state checker FSM.
- Tracks a handshake sequence on i1/i2 through STAGES run stages.
- Adds a per-stage timeout, an error-cause code and a selectable sticky error.
- Sits between a control source and downstream logic, which consumes busy/done/err flags.

---
 rtl/sm_seq_pkg.sv | 23 ++
 rtl/sm_seq_timer.sv | 36 +++
 rtl/sm_seq_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sm_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | sm_seq_pkg : shared state and error-cause encodings for sm_seq_gen       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package sm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_START = 2'd1;
  localparam logic [1:0] ERR_SEQ   = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sm_seq_timer.sv
// +--------------------------------------------------------------------------+
// | sm_seq_timer : saturating per-stage timer, expire at TIMEOUT-1           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sm_seq_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] c_last = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != c_last)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/sm_seq_gen.sv
// +--------------------------------------------------------------------------+
// | sm_seq_gen : multi-stage i1/i2 handshake checker with timeout and error  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sm_seq_gen
  import sm_seq_pkg::*;
#(
  parameter int STAGES     = 4,
  parameter int TIMEOUT    = 8,
  parameter int ERR_STICKY = 1,
  localparam int CW        = $clog2(STAGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i1,
  input  logic          i2,
  input  logic          clr,
  output logic          o1,
  output logic          o2,
  output logic          err,
  output logic [CW-1:0] stage,
  output logic [1:0]    err_code
);

  localparam logic [CW-1:0] c_last_stage = CW'(STAGES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] w_stage_nxt;
  logic [1:0]    w_code_nxt;
  logic          w_tmr_clr;
  logic          w_tmr_en;
  logic          w_expire;
  logic          w_go;
  logic          w_bad;
  logic          w_leave_err;

  assign w_go        = i1 & i2;
  assign w_bad       = i1 & ~i2;
  assign w_leave_err = (ERR_STICKY != 0) ? (clr & ~i1) : ~i1;

  sm_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_tmr_clr),
    .enable (w_tmr_en),
    .expire (w_expire)
  );

  // Timer is cleared in every case except an idle/hold cycle that stays in RUN.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_stage_nxt = '0;
    w_code_nxt  = ERR_NONE;
    w_tmr_clr   = 1'b1;
    w_tmr_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_RUN;
        end else if (w_bad) begin
          w_state_nxt = ST_ERR;
          w_code_nxt  = ERR_START;
        end
      end
      ST_RUN: begin
        if (w_go) begin
          if (stage == c_last_stage) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
            w_stage_nxt = stage + 1'b1;
          end
        end else if (w_bad) begin
          w_state_nxt = ST_ERR;
          w_code_nxt  = ERR_SEQ;
        end else if (w_expire) begin
          w_state_nxt = ST_ERR;
          w_code_nxt  = ERR_TMO;
        end else begin
          w_state_nxt = ST_RUN;
          w_stage_nxt = stage;
          w_tmr_clr   = 1'b0;
          w_tmr_en    = 1'b1;
        end
      end
      ST_DONE: begin
        if (w_go) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_ERR: begin
        if (!w_leave_err) begin
          w_state_nxt = ST_ERR;
          w_code_nxt  = err_code;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Flags are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      stage    <= '0;
      err_code <= ERR_NONE;
      o1       <= 1'b0;
      o2       <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      stage    <= w_stage_nxt;
      err_code <= w_code_nxt;
      o1       <= (w_state_nxt == ST_RUN);
      o2       <= (w_state_nxt == ST_DONE);
      err      <= (w_state_nxt == ST_ERR);
    end
  end

endmodule

`default_nettype wire
